// File: rtl/mac_pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pe_pkg
// Purpose  : Shared types and sizing helpers for the MAC processing element.
//            - pe_state_t : controller state encoding
//            - acc_width  : accumulator width that can never overflow
//            - sat_limit  : largest positive value of a signed DATA_W word
// Revision : 1.0 - initial release
// ============================================================================
package mac_pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } pe_state_t;

    // Each product needs 2*DATA_W bits; summing up to DEPTH of them needs
    // clog2(DEPTH) extra bits of headroom.
    function automatic int acc_width(input int data_w, input int depth);
        return 2 * data_w + $clog2(depth);
    endfunction

    function automatic int sat_limit(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

endpackage : mac_pe_pkg
`default_nettype wire

// File: rtl/pe_weight_bank.sv
`default_nettype none
// ============================================================================
// Module   : pe_weight_bank
// Purpose  : DEPTH x DATA_W weight store, one synchronous write port and one
//            asynchronous read port. Contents are not reset.
// Ports    : clk                 - clock
//            wr_en/wr_addr/wr_data - write port (committed on rising edge)
//            rd_addr/rd_data     - combinational read port
// Revision : 1.0 - initial release
// ============================================================================
module pe_weight_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic signed [DATA_W-1:0]   wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic signed [DATA_W-1:0]   rd_data
);

    logic signed [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : pe_weight_bank
`default_nettype wire

// File: rtl/mac_pe.sv
`default_nettype none
// ============================================================================
// Module   : mac_pe
// Purpose  : Streaming signed dot-product engine with double-buffered weight
//            banks and a ReLU + shift + saturate quantizer on the result.
// Ports    : clk, reset (async, active-high)
//            w_wr_en/w_wr_bank/w_wr_addr/w_wr_data - weight write port
//            w_err     - pulse: write to the bank in use was dropped
//            start/cfg_bank/cfg_len - launch a dot product (IDLE only)
//            in_valid/in_ready/in_data    - activation stream
//            out_valid/out_ready/out_data - quantized result
//            busy      - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module mac_pe
    import mac_pe_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 64,
    parameter int FRAC_BITS = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            w_wr_en,
    input  logic                            w_wr_bank,
    input  logic [$clog2(DEPTH)-1:0]        w_wr_addr,
    input  logic signed [DATA_W-1:0]        w_wr_data,
    output logic                            w_err,
    input  logic                            start,
    input  logic                            cfg_bank,
    input  logic [$clog2(DEPTH):0]          cfg_len,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [DATA_W-1:0]        in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic                            busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = acc_width(DATA_W, DEPTH);
    localparam int C_SAT_INT = sat_limit(DATA_W);
    localparam logic signed [ACC_W-1:0] C_SAT = ACC_W'(C_SAT_INT);
    localparam logic [LEN_W-1:0] C_DEPTH = LEN_W'(DEPTH);

    pe_state_t                 r_state;
    logic                      r_bank;
    logic [LEN_W-1:0]          r_len;
    logic [LEN_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_data;
    logic                      r_w_err;

    logic                      w_busy;
    logic                      w_wr_conflict;
    logic                      w_wr_accept;
    logic [1:0]                w_bank_wr_en;
    logic signed [DATA_W-1:0]  w_rd_data [2];
    logic signed [DATA_W-1:0]  w_weight;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_shift;
    logic [DATA_W-1:0]         w_quant;
    logic [LEN_W-1:0]          w_len_clamp;

    assign w_busy = (r_state != ST_IDLE);

    // The bank feeding the running dot product is write-protected; the other
    // bank stays writable so the next weight set can be loaded in parallel.
    assign w_wr_conflict = w_wr_en && w_busy && (w_wr_bank == r_bank);
    assign w_wr_accept   = w_wr_en && !w_wr_conflict;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_bank_wr_en[b] = w_wr_accept && (w_wr_bank == 1'(b));

        pe_weight_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk     (clk),
            .wr_en   (w_bank_wr_en[b]),
            .wr_addr (w_wr_addr),
            .wr_data (w_wr_data),
            .rd_addr (r_idx[ADDR_W-1:0]),
            .rd_data (w_rd_data[b])
        );
    end

    assign w_weight   = w_rd_data[r_bank];
    assign w_prod     = in_data * w_weight;
    assign w_acc_next = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_shift    = w_acc_next >>> FRAC_BITS;

    // Quantize the value the accumulator will hold after this beat, so the
    // result register is loaded on the same edge as the final accumulate.
    always_comb begin
        w_quant = '0;
        if (w_acc_next[ACC_W-1]) begin
            w_quant = '0;
        end else if (w_shift > C_SAT) begin
            w_quant = C_SAT[DATA_W-1:0];
        end else begin
            w_quant = w_shift[DATA_W-1:0];
        end
    end

    always_comb begin
        w_len_clamp = cfg_len;
        if (cfg_len > C_DEPTH) begin
            w_len_clamp = C_DEPTH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bank      <= 1'b0;
            r_len       <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_w_err     <= 1'b0;
        end else begin
            r_w_err <= w_wr_conflict;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bank <= cfg_bank;
                        r_len  <= w_len_clamp;
                        r_idx  <= '0;
                        r_acc  <= '0;
                        if (w_len_clamp == '0) begin
                            r_state     <= ST_OUT;
                            r_out_valid <= 1'b1;
                            r_out_data  <= '0;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_acc <= w_acc_next;
                        r_idx <= r_idx + LEN_W'(1);
                        if (r_idx == r_len - LEN_W'(1)) begin
                            r_state     <= ST_OUT;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_quant;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign w_err     = r_w_err;

endmodule : mac_pe
`default_nettype wire
